// File: rtl/mem_req_bridge.sv
// Single-outstanding LSU-to-memory-model bridge: aligned, byte-masked access after LATENCY wait states.
// Optional MEM_BRIDGE_PERF_EN adds 32-bit load/store/error response counters.
module mem_req_bridge #(
  parameter int unsigned LATENCY   = 1,
  parameter logic [63:0] IDLE_ADDR = 64'h0000_0000_8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_raddr,
  input  logic [63:0] mem_rdata,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask
`ifdef MEM_BRIDGE_PERF_EN
  ,
  output logic [31:0] perf_rd_cnt,
  output logic [31:0] perf_wr_cnt,
  output logic [31:0] perf_err_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t      r_state, w_state_nxt;
  logic [63:0] r_addr, r_wdata, r_rdata;
  logic        r_wen, r_signed, r_err;
  logic [1:0]  r_size;
  logic [3:0]  r_cnt;

  logic        w_misaligned, w_access;
  logic [2:0]  w_off;
  logic [7:0]  w_wmask;
  logic [63:0] w_lane, w_load;

  always_comb begin
    w_misaligned = 1'b0;
    case (req_size)
      2'd0: w_misaligned = 1'b0;
      2'd1: w_misaligned = req_addr[0];
      2'd2: w_misaligned = |req_addr[1:0];
      2'd3: w_misaligned = |req_addr[2:0];
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_misaligned)      w_state_nxt = S_RESP;
          else if (LATENCY == 0) w_state_nxt = S_ACCESS;
          else                   w_state_nxt = S_WAIT;
        end
      end
      S_WAIT:   if (r_cnt == 4'd0) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   if (resp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign w_off = r_addr[2:0];

  always_comb begin
    w_wmask = 8'h00;
    case (r_size)
      2'd0: w_wmask = 8'h01 << w_off;
      2'd1: w_wmask = 8'h03 << w_off;
      2'd2: w_wmask = 8'h0F << w_off;
      2'd3: w_wmask = 8'hFF << w_off;
    endcase
  end

  assign w_lane = mem_rdata >> {w_off, 3'b000};

  always_comb begin
    w_load = w_lane;
    case (r_size)
      2'd0: w_load = {{56{r_signed & w_lane[7]}},  w_lane[7:0]};
      2'd1: w_load = {{48{r_signed & w_lane[15]}}, w_lane[15:0]};
      2'd2: w_load = {{32{r_signed & w_lane[31]}}, w_lane[31:0]};
      2'd3: w_load = w_lane;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wen    <= 1'b0;
      r_size   <= 2'd0;
      r_signed <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr   <= req_addr;
            r_wen    <= req_wen;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_wdata  <= req_wdata;
            r_err    <= w_misaligned;
            r_rdata  <= '0;
            r_cnt    <= LAT_M1;
          end
        end
        S_WAIT:   r_cnt <= r_cnt - 4'd1;
        S_ACCESS: r_rdata <= r_wen ? 64'd0 : w_load;
        default:  ;
      endcase
    end
  end

  // Every output is gated by reset so the memory model never sees a write while reset is high.
  assign w_access   = (r_state == S_ACCESS) && !reset;
  assign req_ready  = (r_state == S_IDLE) && !reset;
  assign resp_valid = (r_state == S_RESP) && !reset;
  assign resp_rdata = reset ? 64'd0 : r_rdata;
  assign resp_err   = reset ? 1'b0 : r_err;
  assign mem_raddr  = w_access ? {r_addr[63:3], 3'b000} : IDLE_ADDR;
  assign mem_waddr  = w_access ? {r_addr[63:3], 3'b000} : IDLE_ADDR;
  assign mem_wdata  = (w_access && r_wen) ? (r_wdata << {w_off, 3'b000}) : 64'd0;
  assign mem_wmask  = (w_access && r_wen) ? w_wmask : 8'h00;

`ifdef MEM_BRIDGE_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_rd_cnt  <= '0;
      perf_wr_cnt  <= '0;
      perf_err_cnt <= '0;
    end else if (r_state == S_RESP && resp_ready) begin
      if (r_err)      perf_err_cnt <= perf_err_cnt + 32'd1;
      else if (r_wen) perf_wr_cnt  <= perf_wr_cnt + 32'd1;
      else            perf_rd_cnt  <= perf_rd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_bridge.sv
// Directed bench for mem_req_bridge (LATENCY = 1): reset, stores, loads, errors, backpressure, reset abort.
module tb_mem_req_bridge;
  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen, req_signed;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic [63:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic [7:0]  mem_wmask;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [63:0] IDLE = 64'h0000_0000_8000_0000;

  mem_req_bridge dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Presents one request for a single cycle; returns in cycle T+1.
  task automatic issue(input logic [63:0] addr, input logic wen, input logic [1:0] size,
                       input logic sgn, input logic [63:0] wdata);
    req_addr = addr; req_wen = wen; req_size = size; req_signed = sgn; req_wdata = wdata;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    req_addr = 64'hFFFF_FFFF_FFFF_FFF8; req_wdata = '1; req_wen = ~wen;
  endtask

  task automatic respond();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      total_cnt++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b want 0", req_ready); else pass_cnt++;
      total_cnt++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else pass_cnt++;
      total_cnt++; if (mem_wmask !== 8'h00) $display("FAIL rst_wmask: got %h want 00", mem_wmask); else pass_cnt++;
      total_cnt++; if (mem_raddr !== IDLE) $display("FAIL rst_raddr: got %h want %h", mem_raddr, IDLE); else pass_cnt++;
      step();
    end
    reset = 1'b0;
    @(negedge clock);
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", req_ready); else pass_cnt++;
    step();
  endtask

  task automatic test_store_d();
    logic [63:0] wd;
    wd = 64'h1122_3344_5566_7788;
    issue(64'h8000_0008, 1'b1, 2'd3, 1'b0, wd);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      total_cnt++;
      if (mem_wmask !== ((k == 2) ? 8'hFF : 8'h00))
        $display("FAIL sd_wmask_c%0d: got %h want %h", k, mem_wmask, (k == 2) ? 8'hFF : 8'h00);
      else pass_cnt++;
      if (k == 2) begin
        total_cnt++; if (mem_waddr !== 64'h8000_0008) $display("FAIL sd_waddr: got %h want 80000008", mem_waddr); else pass_cnt++;
        total_cnt++; if (mem_wdata !== wd) $display("FAIL sd_wdata: got %h want %h", mem_wdata, wd); else pass_cnt++;
      end
      total_cnt++;
      if (resp_valid !== (k >= 3)) $display("FAIL sd_resp_valid_c%0d: got %b want %b", k, resp_valid, k >= 3);
      else pass_cnt++;
      if (k == 3) begin
        total_cnt++; if (resp_err !== 1'b0) $display("FAIL sd_err: got %b want 0", resp_err); else pass_cnt++;
        total_cnt++; if (resp_rdata !== 64'd0) $display("FAIL sd_rdata: got %h want 0", resp_rdata); else pass_cnt++;
      end
      step();
    end
    respond();
  endtask

  task automatic test_load_byte();
    logic [63:0] exp;
    mem_rdata = 64'h0000_8000_0000_0000;
    for (int s = 1; s >= 0; s--) begin
      exp = (s == 1) ? 64'hFFFF_FFFF_FFFF_FF80 : 64'h0000_0000_0000_0080;
      issue(64'h8000_0005, 1'b0, 2'd0, s[0], 64'hDEAD);
      step();
      @(negedge clock);
      total_cnt++; if (mem_raddr !== 64'h8000_0000) $display("FAIL lb_raddr: got %h want 80000000", mem_raddr); else pass_cnt++;
      total_cnt++; if (mem_wmask !== 8'h00) $display("FAIL lb_wmask: got %h want 00", mem_wmask); else pass_cnt++;
      step();
      @(negedge clock);
      total_cnt++; if (resp_valid !== 1'b1) $display("FAIL lb_resp_valid: got %b want 1", resp_valid); else pass_cnt++;
      total_cnt++; if (resp_rdata !== exp) $display("FAIL lb_rdata_s%0d: got %h want %h", s, resp_rdata, exp); else pass_cnt++;
      step();
      respond();
    end
  endtask

  task automatic test_load_half_word();
    mem_rdata = 64'h0000_0000_F00D_0000;
    issue(64'h8000_0022, 1'b0, 2'd1, 1'b1, 64'd0);
    step(); step();
    @(negedge clock);
    total_cnt++; if (resp_rdata !== 64'hFFFF_FFFF_FFFF_F00D) $display("FAIL lh_rdata: got %h want FFFFFFFFFFFFF00D", resp_rdata); else pass_cnt++;
    step();
    respond();
    mem_rdata = 64'h8765_4321_9ABC_DEF0;
    issue(64'h8000_0004, 1'b0, 2'd2, 1'b1, 64'd0);
    step(); step();
    @(negedge clock);
    total_cnt++; if (resp_rdata !== 64'hFFFF_FFFF_8765_4321) $display("FAIL lw_rdata: got %h want FFFFFFFF87654321", resp_rdata); else pass_cnt++;
    step();
    respond();
  endtask

  task automatic test_store_h();
    issue(64'h8000_0006, 1'b1, 2'd1, 1'b0, 64'h0000_0000_0000_BEEF);
    step();
    @(negedge clock);
    total_cnt++; if (mem_wmask !== 8'hC0) $display("FAIL sh_wmask: got %h want C0", mem_wmask); else pass_cnt++;
    total_cnt++; if (mem_wdata !== 64'hBEEF_0000_0000_0000) $display("FAIL sh_wdata: got %h want BEEF000000000000", mem_wdata); else pass_cnt++;
    total_cnt++; if (mem_waddr !== 64'h8000_0000) $display("FAIL sh_waddr: got %h want 80000000", mem_waddr); else pass_cnt++;
    step();
    respond();
  endtask

  task automatic test_misaligned();
    issue(64'h8000_0002, 1'b0, 2'd2, 1'b0, 64'd0);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clock);
      total_cnt++; if (resp_valid !== 1'b1) $display("FAIL mis_resp_valid_c%0d: got %b want 1", k, resp_valid); else pass_cnt++;
      total_cnt++; if (resp_err !== 1'b1) $display("FAIL mis_err_c%0d: got %b want 1", k, resp_err); else pass_cnt++;
      total_cnt++; if (resp_rdata !== 64'd0) $display("FAIL mis_rdata: got %h want 0", resp_rdata); else pass_cnt++;
      total_cnt++; if (mem_wmask !== 8'h00) $display("FAIL mis_wmask: got %h want 00", mem_wmask); else pass_cnt++;
      total_cnt++; if (mem_raddr !== IDLE) $display("FAIL mis_raddr: got %h want %h", mem_raddr, IDLE); else pass_cnt++;
      step();
    end
    respond();
  endtask

  task automatic test_resp_hold();
    mem_rdata = 64'h1234_5678_9ABC_DEF0;
    issue(64'h8000_0004, 1'b0, 2'd2, 1'b0, 64'd0);
    step(); step();
    mem_rdata = 64'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      total_cnt++; if (resp_valid !== 1'b1) $display("FAIL hold_valid_c%0d: got %b want 1", k, resp_valid); else pass_cnt++;
      total_cnt++; if (resp_rdata !== 64'h0000_0000_1234_5678) $display("FAIL hold_rdata_c%0d: got %h want 12345678", k, resp_rdata); else pass_cnt++;
      total_cnt++; if (resp_err !== 1'b0) $display("FAIL hold_err_c%0d: got %b want 0", k, resp_err); else pass_cnt++;
      total_cnt++; if (req_ready !== 1'b0) $display("FAIL hold_req_ready_c%0d: got %b want 0", k, req_ready); else pass_cnt++;
      step();
    end
    respond();
  endtask

  task automatic test_back_to_back();
    mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    issue(64'h8000_0018, 1'b0, 2'd3, 1'b1, 64'd0);
    step(); step();
    req_addr = 64'h8000_0003; req_wen = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_wdata = 64'h0000_0000_0000_00AB; req_valid = 1'b1; resp_ready = 1'b1;
    @(negedge clock);
    total_cnt++; if (resp_rdata !== 64'hDEAD_BEEF_CAFE_F00D) $display("FAIL b2b_ld_rdata: got %h want DEADBEEFCAFEF00D", resp_rdata); else pass_cnt++;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL b2b_no_turnaround: got %b want 0", req_ready); else pass_cnt++;
    step();
    resp_ready = 1'b0;
    @(negedge clock);
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL b2b_ready_next: got %b want 1", req_ready); else pass_cnt++;
    total_cnt++; if (resp_valid !== 1'b0) $display("FAIL b2b_valid_drop: got %b want 0", resp_valid); else pass_cnt++;
    step();
    req_valid = 1'b0;
    step();
    @(negedge clock);
    total_cnt++; if (mem_wmask !== 8'h08) $display("FAIL b2b_sb_wmask: got %h want 08", mem_wmask); else pass_cnt++;
    total_cnt++; if (mem_wdata !== 64'h0000_0000_AB00_0000) $display("FAIL b2b_sb_wdata: got %h want 00000000AB000000", mem_wdata); else pass_cnt++;
    step();
    respond();
  endtask

  task automatic test_reset_abort();
    // Reset during WAIT of a store.
    issue(64'h8000_0010, 1'b1, 2'd3, 1'b0, 64'h5555_AAAA_5555_AAAA);
    reset = 1'b1;
    @(negedge clock);
    total_cnt++; if (mem_wmask !== 8'h00) $display("FAIL abw_wmask_rst: got %h want 00", mem_wmask); else pass_cnt++;
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      total_cnt++; if (mem_wmask !== 8'h00) $display("FAIL abw_wmask_c%0d: got %h want 00", k, mem_wmask); else pass_cnt++;
      total_cnt++; if (resp_valid !== 1'b0) $display("FAIL abw_resp_c%0d: got %b want 0", k, resp_valid); else pass_cnt++;
      total_cnt++; if (req_ready !== 1'b1) $display("FAIL abw_ready_c%0d: got %b want 1", k, req_ready); else pass_cnt++;
      step();
    end
    // Reset during the ACCESS cycle must suppress the write.
    issue(64'h8000_0010, 1'b1, 2'd3, 1'b0, 64'h5555_AAAA_5555_AAAA);
    step();
    reset = 1'b1;
    @(negedge clock);
    total_cnt++; if (mem_wmask !== 8'h00) $display("FAIL aba_wmask: got %h want 00", mem_wmask); else pass_cnt++;
    total_cnt++; if (mem_waddr !== IDLE) $display("FAIL aba_waddr: got %h want %h", mem_waddr, IDLE); else pass_cnt++;
    step();
    reset = 1'b0;
    @(negedge clock);
    total_cnt++; if (resp_valid !== 1'b0) $display("FAIL aba_resp: got %b want 0", resp_valid); else pass_cnt++;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL aba_ready: got %b want 1", req_ready); else pass_cnt++;
    step();
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_wen = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_wdata = '0; resp_ready = 1'b0; mem_rdata = '0;
    #1;
    test_reset();
    test_store_d();
    test_load_byte();
    test_load_half_word();
    test_store_h();
    test_misaligned();
    test_resp_hold();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mem_req_bridge.md
Name: mem_req_bridge

Overview:
- Sits directly upstream of the DPI-C memory model in the npc playground.
- Accepts one load/store request at a time from the core LSU over a valid/ready handshake.
- Converts each request into a single 8-byte-aligned, byte-masked access on the memory model's combinational read/write port, with programmable wait states.
- Returns load data shifted, sized and sign/zero-extended over a valid/ready response channel.

Parameters:
- LATENCY, 1, wait-state cycles before the access cycle; legal range 0..15.
- IDLE_ADDR, 64'h0000_0000_8000_0000, value driven on mem_raddr/mem_waddr whenever no access is in progress.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request valid
- req_ready  out  1  bridge can accept a request
- req_addr  in  64  byte address
- req_wen  in  1  1 = store, 0 = load
- req_size  in  2  0 = B, 1 = H, 2 = W, 3 = D
- req_signed  in  1  load sign-extension; ignored for stores and size D
- req_wdata  in  64  store data, LSB-justified
- resp_valid  out  1  response valid
- resp_ready  in  1  response accepted
- resp_rdata  out  64  load result; 0 for stores and errors
- resp_err  out  1  misaligned request
- mem_raddr  out  64  aligned read address to memory model
- mem_rdata  in  64  combinational read data from memory model
- mem_waddr  out  64  aligned write address to memory model
- mem_wdata  out  64  lane-positioned write data
- mem_wmask  out  8  byte write enables; nonzero only in the store ACCESS cycle

Behaviour:
- The memory model reads and writes on every evaluation. Therefore mem_wmask is 0 in every cycle except a store's single ACCESS cycle, and is forced to 0 while reset=1.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- Reset state is IDLE. Outputs while reset is high: req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_raddr = mem_waddr = IDLE_ADDR, mem_wdata = 0, mem_wmask = 0.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch addr, wen, size, signed and wdata.
  - Misaligned request (addr modulo 2^size != 0): go to RESP with err = 1 and rdata = 0. No memory access occurs.
  - Otherwise go to WAIT if LATENCY > 0, else go to ACCESS.
- WAIT: a 4-bit counter runs LATENCY cycles, then the FSM goes to ACCESS.
- ACCESS (exactly one cycle):
  - mem_raddr = mem_waddr = {addr[63:3], 3'b000}; off = addr[2:0].
  - Store: mem_wmask = ((1 << 2^size) - 1) << off, truncated to 8 bits. mem_wdata = req_wdata << (8*off), truncated to 64 bits.
  - Load: mem_wmask = 0. Register (mem_rdata >> 8*off), truncated to the access size, then sign-extended if signed and size < 3, else zero-extended.
  - Next state is RESP.
- RESP:
  - resp_valid = 1.
  - resp_rdata and resp_err are held stable until resp_ready.
  - On resp_valid & resp_ready, return to IDLE. The next request can be accepted in the following cycle (no same-cycle turnaround).
- Timing: for a handshake at the edge ending cycle T:
  - WAIT occupies T+1 .. T+LATENCY.
  - ACCESS occurs in T+LATENCY+1.
  - resp_valid first asserts in T+LATENCY+2.
  - A misaligned request asserts resp_valid in T+1.
- req_ready = 0 in WAIT, ACCESS and RESP. Input changes in those states are ignored.
- Reset asserted mid-operation: at the next edge the FSM returns to IDLE and the transaction is dropped with no response. If the FSM is in ACCESS during the reset cycle, mem_wmask is still 0, so no partial write occurs.
- Outside ACCESS: mem_raddr = mem_waddr = IDLE_ADDR, mem_wdata = 0.

Optional Feature:
- Macro: MEM_BRIDGE_PERF_EN.
- When defined:
  - Adds outputs perf_rd_cnt, perf_wr_cnt and perf_err_cnt, each 32 bits.
  - Each counter increments by 1 on the response handshake of a completed load, a completed store, or an errored request respectively.
  - Counters wrap from 0xFFFF_FFFF to 0 and are cleared by reset.
- When not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset held 2 cycles, then released -> during reset req_ready = 0, resp_valid = 0, mem_wmask = 0, mem_raddr = 0x8000_0000; one cycle after release req_ready = 1.
- LATENCY = 1, SD at 0x8000_0008, wdata 0x1122_3344_5566_7788 -> exactly one cycle (T+2) with mem_wmask = 0xFF, mem_waddr = 0x8000_0008 and that wdata; resp_valid at T+3 with err = 0, rdata = 0.
- LB at 0x8000_0005 with mem_rdata = 0x0000_8000_0000_0000 -> signed: resp_rdata = 0xFFFF_FFFF_FFFF_FF80; unsigned: 0x0000_0000_0000_0080; mem_raddr = 0x8000_0000 in the ACCESS cycle.
- SH at 0x8000_0006, wdata 0xBEEF -> mem_wmask = 0xC0, mem_wdata[63:48] = 0xBEEF, other bytes 0.
- LW at 0x8000_0002 -> no ACCESS cycle (mem_wmask stays 0, mem_raddr stays IDLE_ADDR); resp_valid at T+1 with err = 1, rdata = 0.
- resp_ready held low 3 cycles in RESP -> resp_valid, resp_rdata and resp_err stable and req_ready = 0. Separately, reset pulsed during WAIT of an SD -> mem_wmask never nonzero, no response, req_ready = 1 after release.
